gf180mcu_ocd_ip_sram__sram512x8_ctrl: RTL and testbench
=======================================================

# gf180mcu_ocd_ip_sram__sram512x8_ctrl

Single-port requester that drives a 512x8 bit-maskable SRAM macro (CLK/CEN/GWEN/WEN/A/D/Q pin set). It sits between fabric logic and the macro. It turns a valid/ready request stream into macro pin activity and returns read data through a 3-entry response FIFO with valid/ready backpressure. After reset it optionally zero-fills the whole array before it accepts any request.

## Interface
- INIT_EN, 1, when 1, sweep-write INIT_VALUE to all 512 words after reset; when 0, start directly in RUN
- INIT_VALUE, 8'h00, fill value for the init sweep
- CLK  in  1  clock; the macro is clocked by the same CLK
- RESETN  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready at a rising CLK edge
- req_we  in  1  1 = write, 0 = read
- req_addr  in  9  word address
- req_wdata  in  8  write data
- req_wmask  in  8  write bit enables, active-high; bit i = 1 writes bit i
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer accepts rsp_rdata
- rsp_rdata  out  8  read data, in request order
- init_done  out  1  high once the controller is in RUN
- sram_cen  out  1  to macro CEN, active-low
- sram_gwen  out  1  to macro GWEN, active-low (0 = write)
- sram_wen  out  8  to macro WEN, active-low per bit (= ~req_wmask)
- sram_a  out  9  to macro A
- sram_d  out  8  to macro D
- sram_q  in  8  from macro Q

## Operation
- FSM states: INIT, RUN. RESETN low forces INIT when INIT_EN=1, or RUN when INIT_EN=0.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, init_done=0 (1 if INIT_EN=0), sram_cen=1, sram_gwen=1, sram_wen=8'hFF, sram_a=0, sram_d=0. FIFO is emptied and the in-flight counter is cleared.
- INIT:
  - 9-bit counter addr_cnt runs 0..511, one write per cycle: sram_cen=0, sram_gwen=0, sram_wen=8'h00, sram_a=addr_cnt, sram_d=INIT_VALUE.
  - After the write to 511 the FSM moves to RUN, and init_done goes high the following cycle.
  - req_ready=0 throughout INIT.
- RUN:
  - req_ready = (fifo_count + inflight < 3). It is registered-state only, with no combinational path from rsp_ready.
  - Macro pins are combinational from the handshake. When fire = req_valid && req_ready: sram_cen=0, sram_gwen=~req_we, sram_wen=~req_wmask, sram_a=req_addr, sram_d=req_wdata.
  - When fire is 0: idle values (cen=1, gwen=1, wen=FF, a=0, d=0).
  - A read sets inflight=1 for the next cycle. In that cycle sram_q is pushed into the FIFO.
  - Writes produce no response and consume no credit.
  - A write with req_wmask=0 still asserts CEN but changes no bits.
- FIFO: 3 entries, in-order. rsp_valid = !empty and rsp_rdata = head; it pops on rsp_valid && rsp_ready. Simultaneous push and pop are supported, and the count is unchanged.
- Overflow is impossible by the credit rule. rsp_ready low indefinitely stalls the request side once 3 credits are used.
- Reset asserted mid-operation discards in-flight reads and FIFO contents and restarts INIT. The macro pins return to idle values immediately (asynchronously).

## Timing
- The INIT sweep takes exactly 512 cycles from the first CLK edge after RESETN deasserts. init_done rises on cycle 513.
- Read latency: the request is accepted at edge N and the macro samples at the same edge. sram_q is valid during cycle N+1 and is captured at edge N+1. rsp_valid is high from cycle N+2 (2 cycles).
- Throughput: 1 request/cycle sustained when rsp_ready is held high.
- Write at edge N followed by a read of the same address at edge N+1 returns the new data.
- rsp_valid/rsp_rdata are held stable while rsp_valid && !rsp_ready.

## Test plan
- Reset with INIT_EN=1:
  - sram_a steps 0..511 with gwen=0 and wen=00 for 512 cycles; req_ready=0 during the sweep; init_done=1 on cycle 513.
  - Reading addresses 0, 255, 511 returns 8'h00.
- Write addr 9'h0A5 data 8'h3C mask FF, then read 9'h0A5 -> rsp_rdata=8'h3C, rsp_valid exactly 2 cycles after read acceptance.
- Masked write: write 8'hFF mask FF to addr 7, then 8'h00 mask 8'h0F to the same address, then read -> 8'hF0; observe sram_wen=8'hF0 on the second write.
- Backpressure: hold rsp_ready=0 and issue 5 reads of addresses 1..5 -> exactly 3 accepted, req_ready=0 after that. Release rsp_ready -> data is returned in order 1..5 with no loss or duplication.
- Throughput: 16 back-to-back reads with rsp_ready=1 -> req_ready stays high and 16 consecutive rsp_valid cycles appear.
- Assert RESETN low while 2 responses are queued and 1 read is in flight -> rsp_valid=0 and sram_cen=1 immediately. After release, the INIT sweep restarts at address 0 and no stale responses appear.

Source files
------------

// File: rtl/gf180mcu_ocd_ip_sram__sram512x8_ctrl.sv
// rtl/gf180mcu_ocd_ip_sram__sram512x8_ctrl.sv - 512x8 SRAM macro requester with init sweep and 3-entry response FIFO
//
// Purpose: turns a valid/ready request stream into CEN/GWEN/WEN/A/D pin
// activity on a single-port 512x8 bit-maskable SRAM macro and returns read
// data, in order, through a 3-entry response FIFO. After reset the whole
// array is optionally written with INIT_VALUE before requests are accepted.
//
// Ports:
//   CLK, RESETN           clock (shared with the macro), async active-low reset
//   req_valid/req_ready   request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   word address and write data
//   req_wmask             active-high per-bit write enable
//   rsp_valid/rsp_ready   response handshake, rsp_rdata = FIFO head
//   init_done             high while in RUN
//   sram_cen/gwen/wen/a/d macro inputs (active-low controls)
//   sram_q                macro read data, valid the cycle after a read

`timescale 1ns/1ps

module gf180mcu_ocd_ip_sram__sram512x8_ctrl #(
    parameter bit         INIT_EN    = 1'b1,
    parameter logic [7:0] INIT_VALUE = 8'h00
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_we,
    input  logic [8:0] req_addr,
    input  logic [7:0] req_wdata,
    input  logic [7:0] req_wmask,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       init_done,
    output logic       sram_cen,
    output logic       sram_gwen,
    output logic [7:0] sram_wen,
    output logic [8:0] sram_a,
    output logic [7:0] sram_d,
    input  logic [7:0] sram_q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE = INIT_EN ? ST_INIT : ST_RUN;

    state_t     state;
    state_t     state_nxt;
    logic [8:0] addr_cnt;
    logic [8:0] addr_cnt_nxt;

    // One read may be between macro sample and FIFO push at any time.
    logic       inflight;

    logic [7:0] fifo_mem [3];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [1:0] fifo_count;

    logic [2:0] credits_used;
    logic       fire;
    logic       rd_fire;
    logic       push;
    logic       pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credits cover both queued entries and the read whose data is still
    // on sram_q, so the FIFO can never overflow. Depends on registered
    // state only; rsp_ready does not reach req_ready.
    assign credits_used = {1'b0, fifo_count} + {2'b00, inflight};
    assign req_ready    = RESETN && (state == ST_RUN) && (credits_used < 3'd3);
    assign fire         = req_valid && req_ready;
    assign rd_fire      = fire && !req_we;

    assign push      = inflight;
    assign rsp_valid = (fifo_count != 2'd0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr] : 8'h00;

    assign init_done = (state == ST_RUN);

    always_comb begin
        state_nxt    = state;
        addr_cnt_nxt = addr_cnt;
        case (state)
            ST_INIT: begin
                addr_cnt_nxt = addr_cnt + 9'd1;
                if (addr_cnt == 9'd511) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                addr_cnt_nxt = 9'd0;
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // Macro pins. Gated by RESETN so reset idles the macro without waiting
    // for a clock edge (the INIT state would otherwise drive a write).
    always_comb begin
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = 8'hFF;
        sram_a    = 9'd0;
        sram_d    = 8'h00;
        if (RESETN) begin
            if (state == ST_INIT) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = 8'h00;
                sram_a    = addr_cnt;
                sram_d    = INIT_VALUE;
            end else if (fire) begin
                sram_cen  = 1'b0;
                sram_gwen = ~req_we;
                sram_wen  = ~req_wmask;
                sram_a    = req_addr;
                sram_d    = req_wdata;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state      <= RESET_STATE;
            addr_cnt   <= 9'd0;
            inflight   <= 1'b0;
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 2'd0;
        end else begin
            state    <= state_nxt;
            addr_cnt <= addr_cnt_nxt;
            inflight <= rd_fire;
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible behind rsp_valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= sram_q;
        end
    end

endmodule

// File: tb/tb_gf180mcu_ocd_ip_sram__sram512x8_ctrl.sv
// tb/tb_gf180mcu_ocd_ip_sram__sram512x8_ctrl.sv - self-checking bench for the SRAM requester

`timescale 1ns/1ps

module tb_gf180mcu_ocd_ip_sram__sram512x8_ctrl;

    localparam logic [7:0] INIT_VALUE = 8'h00;

    logic       CLK = 1'b0;
    logic       RESETN;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [8:0] req_addr;
    logic [7:0] req_wdata;
    logic [7:0] req_wmask;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       init_done;
    logic       sram_cen;
    logic       sram_gwen;
    logic [7:0] sram_wen;
    logic [8:0] sram_a;
    logic [7:0] sram_d;
    logic [7:0] sram_q;

    always #5 CLK = ~CLK;

    gf180mcu_ocd_ip_sram__sram512x8_ctrl #(
        .INIT_EN    (1'b1),
        .INIT_VALUE (INIT_VALUE)
    ) dut (
        .CLK       (CLK),
        .RESETN    (RESETN),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_a    (sram_a),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    // Macro behaviour: synchronous, Q updated on read cycles only.
    logic [7:0] macro_mem [512];
    initial sram_q = 8'h00;
    always @(posedge CLK) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                for (int i = 0; i < 8; i++) begin
                    if (!sram_wen[i]) macro_mem[sram_a][i] <= sram_d[i];
                end
            end else begin
                sram_q <= macro_mem[sram_a];
            end
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: array contents plus the ordered list of read
    // results still owed to the consumer (in flight or queued).
    logic [7:0] ref_mem [512];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         mon_en = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         run = 0;
    int         maxrun = 0;

    always @(negedge CLK) begin
        if (mon_en && RESETN) begin
            chk("req_ready_credit", req_ready, exp_q.size() < 3);
            if (prev_stall) begin
                chk("stall_valid_hold", rsp_valid, 1);
                chk("stall_data_hold", rsp_rdata, prev_data);
            end
            if (rsp_valid && exp_q.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else if (rsp_valid && rsp_ready) begin
                chk("rsp_data", rsp_rdata, exp_q.pop_front());
                got_q.push_back(rsp_rdata);
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_rdata;
            run        = rsp_valid ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (req_valid && req_ready) begin
                if (req_we)
                    ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
                else
                    exp_q.push_back(ref_mem[req_addr]);
            end
        end else begin
            prev_stall = 1'b0;
            run        = 0;
        end
    end

    typedef struct {
        logic       we;
        logic [8:0] addr;
        logic [7:0] wdata;
        logic [7:0] wmask;
        logic [7:0] exp_wen;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vt [8];

    task automatic wait_ready(output bit ok, output int n);
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 64) begin
            @(negedge CLK);
            n++;
        end
        ok = req_ready;
        if (!ok) chk("req_ready_timeout", 0, 1);
    endtask

    task automatic issue(input bit we, input logic [8:0] addr, input logic [7:0] wdata,
                         input logic [7:0] wmask, output int n);
        bit ok;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        wait_ready(ok, n);
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        bit ok;
        int n;
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wmask = v.wmask;
        wait_ready(ok, n);
        chk("vec_cen", sram_cen, 0);
        chk("vec_gwen", sram_gwen, !v.we);
        chk("vec_wen", sram_wen, v.exp_wen);
        chk("vec_a", sram_a, v.addr);
        chk("vec_d", sram_d, v.wdata);
        @(posedge CLK); #1;
        req_valid = 1'b0;
        if (!v.we) begin
            @(negedge CLK);
            chk("vec_rsp_not_early", rsp_valid, 0);
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("vec_rsp_valid_n2", rsp_valid, 1);
            chk("vec_rsp_data", rsp_rdata, v.exp_rdata);
            @(posedge CLK); #1;
        end
    endtask

    task automatic run_init_sweep();
        int errs = 0;
        RESETN = 1'b1;
        #1;
        for (int i = 0; i < 512; i++) begin
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 8'h00 ||
                sram_a !== i[8:0] || sram_d !== INIT_VALUE || req_ready !== 1'b0 ||
                init_done !== 1'b0)
                errs++;
            @(posedge CLK); #1;
        end
        chk("init_sweep_errors", errs, 0);
        chk("init_done_cycle513", init_done, 1);
        chk("req_ready_after_init", req_ready, 1);
        chk("cen_idle_after_init", sram_cen, 1);
        for (int i = 0; i < 512; i++) ref_mem[i] = INIT_VALUE;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int acc;
        int stale;

        RESETN    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 9'd0;
        req_wdata = 8'h00;
        req_wmask = 8'h00;
        rsp_ready = 1'b1;

        vt[0] = '{we: 1'b0, addr: 9'd0,   wdata: 8'h00, wmask: 8'h00, exp_wen: 8'hFF, exp_rdata: 8'h00};
        vt[1] = '{we: 1'b0, addr: 9'd255, wdata: 8'h00, wmask: 8'h00, exp_wen: 8'hFF, exp_rdata: 8'h00};
        vt[2] = '{we: 1'b0, addr: 9'd511, wdata: 8'h00, wmask: 8'h00, exp_wen: 8'hFF, exp_rdata: 8'h00};
        vt[3] = '{we: 1'b1, addr: 9'h0A5, wdata: 8'h3C, wmask: 8'hFF, exp_wen: 8'h00, exp_rdata: 8'h00};
        vt[4] = '{we: 1'b0, addr: 9'h0A5, wdata: 8'h00, wmask: 8'h00, exp_wen: 8'hFF, exp_rdata: 8'h3C};
        vt[5] = '{we: 1'b1, addr: 9'd7,   wdata: 8'hFF, wmask: 8'hFF, exp_wen: 8'h00, exp_rdata: 8'h00};
        vt[6] = '{we: 1'b1, addr: 9'd7,   wdata: 8'h00, wmask: 8'h0F, exp_wen: 8'hF0, exp_rdata: 8'h00};
        vt[7] = '{we: 1'b0, addr: 9'd7,   wdata: 8'h00, wmask: 8'h00, exp_wen: 8'hFF, exp_rdata: 8'hF0};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cen", sram_cen, 1);
        chk("rst_gwen", sram_gwen, 1);
        chk("rst_wen", sram_wen, 8'hFF);
        chk("rst_a", sram_a, 0);
        chk("rst_d", sram_d, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_init_done", init_done, 0);

        run_init_sweep();
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(vt[i]);

        // Throughput: back-to-back reads with the consumer always ready.
        repeat (4) @(posedge CLK);
        #1;
        maxrun = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 9'(i * 7), 8'h00, 8'h00, n);
            chk("tput_no_wait", n, 0);
        end
        repeat (5) @(posedge CLK);
        #1;
        chk("tput_rsp_run", maxrun, 16);

        // Backpressure: five reads against a stalled consumer.
        for (int i = 1; i <= 5; i++) issue(1'b1, 9'(i), 8'(8'h10 + i), 8'hFF, n);
        repeat (3) @(posedge CLK);
        #1;
        rsp_ready = 1'b0;
        got_q.delete();
        k   = 1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = (k <= 5);
            req_we    = 1'b0;
            req_addr  = 9'(k);
            @(negedge CLK);
            if (req_valid && req_ready) begin
                acc++;
                k++;
            end
            @(posedge CLK); #1;
        end
        chk("bp_accepted_while_stalled", acc, 3);
        @(negedge CLK);
        chk("bp_req_ready_low", req_ready, 0);
        @(posedge CLK); #1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && k <= 5; c++) begin
            req_valid = 1'b1;
            req_addr  = 9'(k);
            @(negedge CLK);
            if (req_ready) k++;
            @(posedge CLK); #1;
        end
        req_valid = 1'b0;
        chk("bp_all_accepted", k, 6);
        repeat (8) @(posedge CLK);
        #1;
        chk("bp_rsp_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) chk("bp_rsp_order", got_q[i], 8'h11 + 8'(i));
        end

        // Randomised traffic against the reference model.
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 9) < 7);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 9'($urandom_range(0, 15));
            req_wdata = 8'($urandom);
            req_wmask = 8'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            @(posedge CLK); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (8) @(posedge CLK);
        #1;
        chk("rand_drained", exp_q.size(), 0);

        // Reset with two responses queued and one read in flight.
        rsp_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            issue(1'b0, 9'(i), 8'h00, 8'h00, n);
            chk("mid_reset_setup_no_wait", n, 0);
        end
        #2;
        mon_en = 1'b0;
        RESETN = 1'b0;
        #1;
        chk("async_rst_rsp_valid", rsp_valid, 0);
        chk("async_rst_cen", sram_cen, 1);
        chk("async_rst_req_ready", req_ready, 0);
        chk("async_rst_wen", sram_wen, 8'hFF);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        run_init_sweep();
        rsp_ready = 1'b1;
        mon_en    = 1'b1;
        stale     = 0;
        repeat (6) begin
            @(negedge CLK);
            if (rsp_valid) stale++;
        end
        chk("no_stale_rsp", stale, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
